// File: rtl/cr_huf_comp_st_is_pack_if.sv
// Eob marker type plus the symbol-count -> pack bus (4 lanes in, 4 packed lanes out).
package cr_huf_comp_st_is_pack_pkg;
  typedef enum logic [1:0] {MIDDLE = 2'd0, PASS_THRU = 2'd1, EOB = 2'd2, ERR = 2'd3} e_pipe_eob;
endpackage

interface cr_huf_comp_st_is_pack_if #(
  parameter int SYMB_W  = 10,
  parameter int SEQID_W = 8,
  parameter int ENT_W   = 10
) ();
  import cr_huf_comp_st_is_pack_pkg::*;

  logic [3:0]                    sc_is_vld;
  logic [3:0][2:0]               sc_is_cnt;
  logic [3:0][SYMB_W-1:0]        sc_is_symbol;
  logic [SEQID_W-1:0]            sc_is_seq_id;
  e_pipe_eob                     sc_is_eob;
  logic                          sc_is_build_error;
  logic                          is_sc_rd;
  logic [3:0]                    pk_vld;
  logic [3:0][2:0]               pk_cnt;
  logic [3:0][SYMB_W-1:0]        pk_symbol;
  logic [SEQID_W-1:0]            pk_seq_id;
  e_pipe_eob                     pk_eob;
  logic                          pk_build_error;
  logic [ENT_W-1:0]              pk_entry_cnt;
  logic                          pk_overrun;

  modport master (
    output sc_is_vld, sc_is_cnt, sc_is_symbol, sc_is_seq_id, sc_is_eob, sc_is_build_error,
    input  is_sc_rd, pk_vld, pk_cnt, pk_symbol, pk_seq_id, pk_eob, pk_build_error,
           pk_entry_cnt, pk_overrun
  );
  modport slave (
    input  sc_is_vld, sc_is_cnt, sc_is_symbol, sc_is_seq_id, sc_is_eob, sc_is_build_error,
    output is_sc_rd, pk_vld, pk_cnt, pk_symbol, pk_seq_id, pk_eob, pk_build_error,
           pk_entry_cnt, pk_overrun
  );
endinterface

// File: rtl/cr_huf_comp_st_is_pack.sv
// Compacts sparse symbol-count lanes into full 4-lane beats, 1-cycle latency.
// Only backpressure is a one-cycle read stall while a 5..7 lane frame tail flushes.
module cr_huf_comp_st_is_pack
  import cr_huf_comp_st_is_pack_pkg::*;
#(
  parameter int SYMB_W  = 10,
  parameter int SEQID_W = 8,
  parameter int ENT_W   = 10
) (
  input logic clk,
  input logic rst_n,
  cr_huf_comp_st_is_pack_if.slave io
);
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]             r_state;
  logic [1:0]             r_res_n;
  logic [2:0][2:0]        r_res_cnt;
  logic [2:0][SYMB_W-1:0] r_res_sym;
  logic [SEQID_W-1:0]     r_tr_seq;
  e_pipe_eob              r_tr_eob;
  logic                   r_tr_err;
  logic [ENT_W-1:0]       r_ent;
  logic                   r_overrun;
  logic [3:0]             r_pk_vld;
  logic [3:0][2:0]        r_pk_cnt;
  logic [3:0][SYMB_W-1:0] r_pk_sym;
  logic [SEQID_W-1:0]     r_pk_seq;
  e_pipe_eob              r_pk_eob;
  logic                   r_pk_err;
  logic [ENT_W-1:0]       r_pk_ent;

  logic [6:0][2:0]        w_all_cnt;
  logic [6:0][SYMB_W-1:0] w_all_sym;
  logic [2:0]             w_tot;
  logic [2:0]             w_k;

  logic [0:0]             w_n_state;
  logic [1:0]             w_n_res_n;
  logic [2:0][2:0]        w_n_res_cnt;
  logic [2:0][SYMB_W-1:0] w_n_res_sym;
  logic [SEQID_W-1:0]     w_n_tr_seq;
  e_pipe_eob              w_n_tr_eob;
  logic                   w_n_tr_err;
  logic [ENT_W-1:0]       w_n_ent;
  logic                   w_n_overrun;
  logic [3:0]             w_n_pk_vld;
  logic [3:0][2:0]        w_n_pk_cnt;
  logic [3:0][SYMB_W-1:0] w_n_pk_sym;
  logic [SEQID_W-1:0]     w_n_pk_seq;
  e_pipe_eob              w_n_pk_eob;
  logic                   w_n_pk_err;
  logic [ENT_W-1:0]       w_n_pk_ent;

  function automatic logic [3:0] thermo(input logic [2:0] n);
    case (n)
      3'd0:    thermo = 4'b0000;
      3'd1:    thermo = 4'b0001;
      3'd2:    thermo = 4'b0011;
      3'd3:    thermo = 4'b0111;
      default: thermo = 4'b1111;
    endcase
  endfunction

  function automatic logic [ENT_W-1:0] sat_add(input logic [ENT_W-1:0] a, input logic [2:0] b);
    logic [ENT_W:0] s;
    s = {1'b0, a} + {{(ENT_W-2){1'b0}}, b};
    sat_add = s[ENT_W] ? {ENT_W{1'b1}} : s[ENT_W-1:0];
  endfunction

  // Residue first (oldest), then new valid lanes in ascending order; unused slots stay zero.
  always_comb begin
    w_all_cnt = '0;
    w_all_sym = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < int'(r_res_n)) begin
        w_all_cnt[i] = r_res_cnt[i];
        w_all_sym[i] = r_res_sym[i];
      end
    end
    w_k = {1'b0, r_res_n};
    for (int l = 0; l < 4; l++) begin
      if (io.sc_is_vld[l]) begin
        w_all_cnt[w_k] = io.sc_is_cnt[l];
        w_all_sym[w_k] = io.sc_is_symbol[l];
        w_k = w_k + 3'd1;
      end
    end
    w_tot = w_k;
  end

  always_comb begin
    w_n_state   = ST_RUN;
    w_n_res_n   = r_res_n;
    w_n_res_cnt = r_res_cnt;
    w_n_res_sym = r_res_sym;
    w_n_tr_seq  = r_tr_seq;
    w_n_tr_eob  = r_tr_eob;
    w_n_tr_err  = r_tr_err;
    w_n_ent     = r_ent;
    w_n_overrun = r_overrun;
    w_n_pk_vld  = '0;
    w_n_pk_cnt  = '0;
    w_n_pk_sym  = '0;
    w_n_pk_seq  = '0;
    w_n_pk_eob  = MIDDLE;
    w_n_pk_err  = 1'b0;
    w_n_pk_ent  = '0;
    if (r_state == ST_FLUSH) begin
      // Read is stalled this cycle, so anything offered upstream is lost.
      if (io.sc_is_vld != 4'b0000 || io.sc_is_eob != MIDDLE) w_n_overrun = 1'b1;
      w_n_pk_vld  = thermo({1'b0, r_res_n});
      w_n_pk_cnt  = {3'd0, r_res_cnt};
      w_n_pk_sym  = {{SYMB_W{1'b0}}, r_res_sym};
      w_n_pk_seq  = r_tr_seq;
      w_n_pk_eob  = r_tr_eob;
      w_n_pk_err  = r_tr_err;
      w_n_pk_ent  = sat_add(r_ent, {1'b0, r_res_n});
      w_n_ent     = '0;
      w_n_res_n   = '0;
      w_n_res_cnt = '0;
      w_n_res_sym = '0;
    end else if (io.sc_is_eob == MIDDLE || w_tot > 3'd4) begin
      if (w_tot >= 3'd4) begin
        w_n_pk_vld  = 4'b1111;
        w_n_pk_cnt  = w_all_cnt[3:0];
        w_n_pk_sym  = w_all_sym[3:0];
        w_n_res_cnt = w_all_cnt[6:4];
        w_n_res_sym = w_all_sym[6:4];
        w_n_res_n   = 2'(w_tot - 3'd4);
        w_n_ent     = sat_add(r_ent, 3'd4);
      end else begin
        w_n_res_cnt = w_all_cnt[2:0];
        w_n_res_sym = w_all_sym[2:0];
        w_n_res_n   = w_tot[1:0];
      end
      if (io.sc_is_eob != MIDDLE) begin
        w_n_state  = ST_FLUSH;
        w_n_tr_seq = io.sc_is_seq_id;
        w_n_tr_eob = io.sc_is_eob;
        w_n_tr_err = io.sc_is_build_error;
      end
    end else begin
      w_n_pk_vld  = thermo(w_tot);
      w_n_pk_cnt  = w_all_cnt[3:0];
      w_n_pk_sym  = w_all_sym[3:0];
      w_n_pk_seq  = io.sc_is_seq_id;
      w_n_pk_eob  = io.sc_is_eob;
      w_n_pk_err  = io.sc_is_build_error;
      w_n_pk_ent  = sat_add(r_ent, w_tot);
      w_n_ent     = '0;
      w_n_res_n   = '0;
      w_n_res_cnt = '0;
      w_n_res_sym = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_res_n   <= '0;
      r_res_cnt <= '0;
      r_res_sym <= '0;
      r_tr_seq  <= '0;
      r_tr_eob  <= MIDDLE;
      r_tr_err  <= 1'b0;
      r_ent     <= '0;
      r_overrun <= 1'b0;
      r_pk_vld  <= '0;
      r_pk_cnt  <= '0;
      r_pk_sym  <= '0;
      r_pk_seq  <= '0;
      r_pk_eob  <= MIDDLE;
      r_pk_err  <= 1'b0;
      r_pk_ent  <= '0;
    end else begin
      r_state   <= w_n_state;
      r_res_n   <= w_n_res_n;
      r_res_cnt <= w_n_res_cnt;
      r_res_sym <= w_n_res_sym;
      r_tr_seq  <= w_n_tr_seq;
      r_tr_eob  <= w_n_tr_eob;
      r_tr_err  <= w_n_tr_err;
      r_ent     <= w_n_ent;
      r_overrun <= w_n_overrun;
      r_pk_vld  <= w_n_pk_vld;
      r_pk_cnt  <= w_n_pk_cnt;
      r_pk_sym  <= w_n_pk_sym;
      r_pk_seq  <= w_n_pk_seq;
      r_pk_eob  <= w_n_pk_eob;
      r_pk_err  <= w_n_pk_err;
      r_pk_ent  <= w_n_pk_ent;
    end
  end

  assign io.is_sc_rd       = rst_n && (r_state == ST_RUN);
  assign io.pk_vld         = r_pk_vld;
  assign io.pk_cnt         = r_pk_cnt;
  assign io.pk_symbol      = r_pk_sym;
  assign io.pk_seq_id      = r_pk_seq;
  assign io.pk_eob         = r_pk_eob;
  assign io.pk_build_error = r_pk_err;
  assign io.pk_entry_cnt   = r_pk_ent;
  assign io.pk_overrun     = r_overrun;
endmodule

// File: tb/tb_cr_huf_comp_st_is_pack.sv
// Bench for cr_huf_comp_st_is_pack: directed frame scenarios plus random 584-entry frames
// checked against a lane-queue reference model.
module tb_cr_huf_comp_st_is_pack;
  import cr_huf_comp_st_is_pack_pkg::*;
  localparam int SW = 10, QW = 8, EW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cr_huf_comp_st_is_pack_if #(.SYMB_W(SW), .SEQID_W(QW), .ENT_W(EW)) bus ();
  cr_huf_comp_st_is_pack #(.SYMB_W(SW), .SEQID_W(QW), .ENT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus.slave));

  typedef logic [3:0][SW-1:0] sym4_t;
  typedef logic [3:0][2:0]    cnt4_t;
  localparam logic [SW-1:0] X = 10'h3FF;

  function automatic sym4_t mk(input logic [SW-1:0] a, b, c, d);
    sym4_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  function automatic cnt4_t mkc(input logic [2:0] a, b, c, d);
    cnt4_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Present one input cycle, clock it, then return the bus to idle; outputs are then
  // stable (sampled 1 time unit after the edge) and reflect this cycle's inputs.
  task automatic drive(input logic [3:0] vld, input sym4_t sym, input cnt4_t cnt,
                       input e_pipe_eob eob, input logic [QW-1:0] seq, input logic err);
    bus.sc_is_vld = vld; bus.sc_is_symbol = sym; bus.sc_is_cnt = cnt;
    bus.sc_is_eob = eob; bus.sc_is_seq_id = seq; bus.sc_is_build_error = err;
    @(posedge clk); #1;
    bus.sc_is_vld = '0; bus.sc_is_eob = MIDDLE; bus.sc_is_build_error = 1'b0;
  endtask

  task automatic test_reset();
    bus.sc_is_vld = '0; bus.sc_is_symbol = '0; bus.sc_is_cnt = '0;
    bus.sc_is_eob = MIDDLE; bus.sc_is_seq_id = '0; bus.sc_is_build_error = 1'b0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.pk_vld !== 4'b0) begin errors++; $display("FAIL rst_vld: got %h want 0", bus.pk_vld); end
    checks++; if (bus.pk_eob !== MIDDLE || bus.pk_symbol !== '0 || bus.pk_cnt !== '0) begin
      errors++; $display("FAIL rst_lanes: eob %0d sym %h cnt %h want all zero", bus.pk_eob, bus.pk_symbol, bus.pk_cnt); end
    checks++; if (bus.pk_entry_cnt !== '0 || bus.pk_overrun !== 1'b0 || bus.pk_seq_id !== '0 || bus.pk_build_error !== 1'b0) begin
      errors++; $display("FAIL rst_trailer: ent %0d ovr %b seq %h err %b want 0", bus.pk_entry_cnt, bus.pk_overrun, bus.pk_seq_id, bus.pk_build_error); end
    checks++; if (bus.is_sc_rd !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b want 0", bus.is_sc_rd); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.is_sc_rd !== 1'b1) begin errors++; $display("FAIL rst_rd_after: got %b want 1", bus.is_sc_rd); end
  endtask

  task automatic test_back_to_back();
    sym4_t s;
    for (int c = 0; c < 3; c++) begin
      s = mk(SW'(16 * c + 1), SW'(16 * c + 2), SW'(16 * c + 3), SW'(16 * c + 4));
      drive(4'b1111, s, mkc(1, 2, 3, 4), MIDDLE, 8'h00, 1'b0);
      checks++; if (bus.pk_vld !== 4'b1111 || bus.pk_symbol !== s || bus.pk_eob !== MIDDLE || bus.pk_entry_cnt !== '0) begin
        errors++; $display("FAIL b2b_beat%0d: vld %b sym %h eob %0d ent %0d want 1111 %h MIDDLE 0", c, bus.pk_vld, bus.pk_symbol, bus.pk_eob, bus.pk_entry_cnt, s); end
    end
    drive(4'b0000, mk(X, X, X, X), mkc(1, 1, 1, 1), EOB, 8'h11, 1'b0);
    checks++; if (bus.pk_vld !== 4'b0000 || bus.pk_eob !== EOB || bus.pk_seq_id !== 8'h11 || bus.pk_symbol !== '0) begin
      errors++; $display("FAIL b2b_trailer: vld %b eob %0d seq %h want 0000 EOB 11", bus.pk_vld, bus.pk_eob, bus.pk_seq_id); end
    checks++; if (bus.pk_entry_cnt !== 10'd12) begin errors++; $display("FAIL b2b_entry: got %0d want 12", bus.pk_entry_cnt); end
  endtask

  task automatic test_compaction();
    drive(4'b0101, mk(10'h0A1, X, 10'h0B2, X), mkc(1, 2, 3, 4), MIDDLE, 8'h00, 1'b0);
    checks++; if (bus.pk_vld !== 4'b0000 || bus.pk_symbol !== '0) begin
      errors++; $display("FAIL cmp_hold: vld %b sym %h want 0000 0", bus.pk_vld, bus.pk_symbol); end
    drive(4'b1011, mk(10'h0C3, 10'h0D4, X, 10'h0E5), mkc(1, 2, 3, 4), MIDDLE, 8'h00, 1'b0);
    checks++; if (bus.pk_vld !== 4'b1111 || bus.pk_symbol !== mk(10'h0A1, 10'h0B2, 10'h0C3, 10'h0D4)) begin
      errors++; $display("FAIL cmp_full: vld %b sym %h want 1111 0d40c30b20a1", bus.pk_vld, bus.pk_symbol); end
    checks++; if (bus.pk_cnt !== mkc(1, 3, 1, 2)) begin errors++; $display("FAIL cmp_cnt: got %h want %h", bus.pk_cnt, mkc(1, 3, 1, 2)); end
    drive(4'b0000, mk(X, X, X, X), mkc(1, 1, 1, 1), PASS_THRU, 8'h22, 1'b0);
    checks++; if (bus.pk_vld !== 4'b0001 || bus.pk_symbol !== mk(10'h0E5, 0, 0, 0) || bus.pk_cnt !== mkc(4, 0, 0, 0)) begin
      errors++; $display("FAIL cmp_tail: vld %b sym %h cnt %h want 0001 E5 lane0 cnt4", bus.pk_vld, bus.pk_symbol, bus.pk_cnt); end
    checks++; if (bus.pk_entry_cnt !== 10'd5 || bus.pk_eob !== PASS_THRU) begin
      errors++; $display("FAIL cmp_entry: ent %0d eob %0d want 5 PASS_THRU", bus.pk_entry_cnt, bus.pk_eob); end
  endtask

  task automatic test_flush(input bit inject);
    drive(4'b0111, mk(10'h101, 10'h102, 10'h103, X), mkc(2, 2, 2, 2), MIDDLE, 8'h00, 1'b0);
    checks++; if (bus.pk_vld !== 4'b0000) begin errors++; $display("FAIL fl_hold: got %b want 0000", bus.pk_vld); end
    drive(4'b1111, mk(10'h201, 10'h202, 10'h203, 10'h204), mkc(3, 3, 3, 3), EOB, 8'h5A, 1'b1);
    checks++; if (bus.pk_vld !== 4'b1111 || bus.pk_symbol !== mk(10'h101, 10'h102, 10'h103, 10'h201)) begin
      errors++; $display("FAIL fl_full: vld %b sym %h want 1111 2011031021 01", bus.pk_vld, bus.pk_symbol); end
    checks++; if (bus.pk_eob !== MIDDLE || bus.pk_build_error !== 1'b0 || bus.pk_seq_id !== '0 || bus.pk_entry_cnt !== '0) begin
      errors++; $display("FAIL fl_full_trl: eob %0d err %b seq %h ent %0d want MIDDLE 0 0 0", bus.pk_eob, bus.pk_build_error, bus.pk_seq_id, bus.pk_entry_cnt); end
    checks++; if (bus.is_sc_rd !== 1'b0) begin errors++; $display("FAIL fl_rd: got %b want 0", bus.is_sc_rd); end
    drive(inject ? 4'b0001 : 4'b0000, mk(10'h3AA, X, X, X), mkc(1, 1, 1, 1), MIDDLE, 8'h00, 1'b0);
    checks++; if (bus.pk_vld !== 4'b0111 || bus.pk_symbol !== mk(10'h202, 10'h203, 10'h204, 0) || bus.pk_cnt !== mkc(3, 3, 3, 0)) begin
      errors++; $display("FAIL fl_tail: vld %b sym %h cnt %h want 0111 202/203/204", bus.pk_vld, bus.pk_symbol, bus.pk_cnt); end
    checks++; if (bus.pk_seq_id !== 8'h5A || bus.pk_build_error !== 1'b1 || bus.pk_eob !== EOB || bus.pk_entry_cnt !== 10'd7) begin
      errors++; $display("FAIL fl_trailer: seq %h err %b eob %0d ent %0d want 5A 1 EOB 7", bus.pk_seq_id, bus.pk_build_error, bus.pk_eob, bus.pk_entry_cnt); end
    checks++; if (bus.pk_overrun !== inject || bus.is_sc_rd !== 1'b1) begin
      errors++; $display("FAIL fl_overrun: ovr %b rd %b want %b 1", bus.pk_overrun, bus.is_sc_rd, inject); end
    if (inject) begin
      drive(4'b0001, mk(10'h0F0, X, X, X), mkc(2, 1, 1, 1), EOB, 8'h33, 1'b0);
      checks++; if (bus.pk_vld !== 4'b0001 || bus.pk_symbol !== mk(10'h0F0, 0, 0, 0) || bus.pk_entry_cnt !== 10'd1) begin
        errors++; $display("FAIL ovr_dropped: vld %b sym %h ent %0d want 0001 0F0 1", bus.pk_vld, bus.pk_symbol, bus.pk_entry_cnt); end
      checks++; if (bus.pk_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.pk_overrun); end
    end
  endtask

  task automatic test_reset_midframe();
    drive(4'b0011, mk(10'h111, 10'h112, X, X), mkc(1, 1, 1, 1), MIDDLE, 8'h00, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if (bus.pk_overrun !== 1'b0 || bus.is_sc_rd !== 1'b0 || bus.pk_vld !== 4'b0 || bus.pk_entry_cnt !== '0) begin
      errors++; $display("FAIL mrst_outs: ovr %b rd %b vld %b ent %0d want 0 0 0 0", bus.pk_overrun, bus.is_sc_rd, bus.pk_vld, bus.pk_entry_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drive(4'b0011, mk(10'h221, 10'h222, X, X), mkc(4, 3, 1, 1), EOB, 8'h3C, 1'b0);
    checks++; if (bus.pk_vld !== 4'b0011 || bus.pk_symbol !== mk(10'h221, 10'h222, 0, 0) || bus.pk_entry_cnt !== 10'd2) begin
      errors++; $display("FAIL mrst_frame: vld %b sym %h ent %0d want 0011 221/222 2", bus.pk_vld, bus.pk_symbol, bus.pk_entry_cnt); end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 260; c++) drive(4'b1111, mk(1, 2, 3, 4), mkc(1, 1, 1, 1), MIDDLE, 8'h00, 1'b0);
    drive(4'b0000, mk(X, X, X, X), mkc(1, 1, 1, 1), EOB, 8'h44, 1'b0);
    checks++; if (bus.pk_entry_cnt !== 10'd1023 || bus.pk_vld !== 4'b0000) begin
      errors++; $display("FAIL sat_entry: ent %0d vld %b want 1023 0000", bus.pk_entry_cnt, bus.pk_vld); end
  endtask

  // Reference: every accepted valid lane joins an in-order queue; a beat emits 4 lanes once
  // 4 are pending, and the frame end emits what is left (split into 4 + rest above 4).
  task automatic test_random();
    logic [SW-1:0] exp_sym[$];
    logic [2:0]    exp_cnt[$];
    for (int f = 0; f < 3; f++) begin
      int remaining = 584, res = 0, tot, n;
      bit flush = 0, done = 0, last;
      logic [3:0] v, exp_v;
      sym4_t s; cnt4_t c;
      e_pipe_eob eob, exp_eob;
      logic [QW-1:0] seq;
      logic err;
      seq = QW'($urandom); err = 1'(f);
      eob = e_pipe_eob'($urandom_range(1, 3));
      while (!done) begin
        last = 0;
        if (flush) begin
          drive(4'b0000, mk(X, X, X, X), mkc(1, 1, 1, 1), MIDDLE, 8'h00, 1'b0);
          exp_v = 4'((1 << res) - 1); last = 1; flush = 0; done = 1; res = 0;
        end else begin
          if (remaining > 4) v = 4'($urandom);
          else do v = 4'($urandom); while ($countones(v) != remaining);
          for (int l = 0; l < 4; l++) begin
            s[l] = SW'($urandom); c[l] = 3'($urandom_range(1, 4));
            if (v[l]) begin exp_sym.push_back(s[l]); exp_cnt.push_back(c[l]); end
          end
          n = $countones(v); tot = res + n; remaining -= n;
          if (remaining > 0) begin
            exp_v = (tot >= 4) ? 4'b1111 : 4'b0000; res = (tot >= 4) ? tot - 4 : tot;
            drive(v, s, c, MIDDLE, seq, 1'b0);
          end else begin
            if (tot <= 4) begin exp_v = 4'((1 << tot) - 1); last = 1; done = 1; res = 0; end
            else begin exp_v = 4'b1111; res = tot - 4; flush = 1; end
            drive(v, s, c, eob, seq, err);
          end
        end
        exp_eob = last ? eob : MIDDLE;
        checks++; if (bus.pk_vld !== exp_v) begin errors++; $display("FAIL rnd_vld f%0d: got %b want %b", f, bus.pk_vld, exp_v); end
        for (int l = 0; l < 4; l++) begin
          logic [SW-1:0] es; logic [2:0] ec;
          es = '0; ec = '0;
          if (exp_v[l] && exp_sym.size() > 0) begin es = exp_sym.pop_front(); ec = exp_cnt.pop_front(); end
          checks++; if (bus.pk_symbol[l] !== es || bus.pk_cnt[l] !== ec) begin
            errors++; $display("FAIL rnd_lane%0d f%0d: sym %h cnt %0d want %h %0d", l, f, bus.pk_symbol[l], bus.pk_cnt[l], es, ec); end
        end
        checks++; if (bus.pk_eob !== exp_eob) begin errors++; $display("FAIL rnd_eob f%0d: got %0d want %0d", f, bus.pk_eob, exp_eob); end
        if (flush) begin
          checks++; if (bus.is_sc_rd !== 1'b0) begin errors++; $display("FAIL rnd_rd f%0d: got %b want 0", f, bus.is_sc_rd); end
        end
        if (last) begin
          checks++; if (bus.pk_entry_cnt !== 10'd584 || bus.pk_seq_id !== seq || bus.pk_build_error !== err) begin
            errors++; $display("FAIL rnd_trailer f%0d: ent %0d seq %h err %b want 584 %h %b", f, bus.pk_entry_cnt, bus.pk_seq_id, bus.pk_build_error, seq, err); end
        end
      end
      checks++; if (exp_sym.size() != 0) begin errors++; $display("FAIL rnd_leftover f%0d: %0d lanes never emitted, want 0", f, exp_sym.size()); exp_sym.delete(); exp_cnt.delete(); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_compaction();
    test_flush(1'b0);
    test_flush(1'b1);
    test_reset_midframe();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cr_huf_comp_st_is_pack.md
CR_HUF_COMP_ST_IS_PACK -- requirements
Module: cr_huf_comp_st_is_pack

Interface
REQ-001 Parameter SYMB_W, default 10, symbol width (matches CREOLE_HC_ST_SYMB_WIDTH).
REQ-002 Parameter SEQID_W, default 8, sequence-id width (matches CREOLE_HC_SEQID_WIDTH).
REQ-003 Parameter ENT_W, default 10, width of the per-frame entry counter (covers 584 entries).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sc_is_vld  input  4  per-lane valid from the symbol-count stage; any bit pattern is legal.
REQ-007 sc_is_cnt  input  4x3  per-lane repeat count, 1..4 when the lane is valid.
REQ-008 sc_is_symbol  input  4xSYMB_W  per-lane symbol.
REQ-009 sc_is_seq_id, sc_is_eob (e_pipe_eob), sc_is_build_error  input  SEQID_W / e_pipe_eob / 1  frame trailer, meaningful only when sc_is_eob != MIDDLE.
REQ-010 is_sc_rd  output  1  read strobe to the upstream stage.
REQ-011 pk_vld  output  4  packed lane valid; always thermometer (4'b0000, 0001, 0011, 0111, 1111).
REQ-012 pk_cnt, pk_symbol  output  4x3 / 4xSYMB_W  packed lane count and symbol.
REQ-013 pk_seq_id, pk_eob, pk_build_error  output  SEQID_W / e_pipe_eob / 1  trailer, valid on the frame's last packed beat.
REQ-014 pk_entry_cnt  output  ENT_W  number of lanes emitted in the frame, valid with pk_eob != MIDDLE.
REQ-015 pk_overrun  output  1  sticky error: input arrived while a flush was pending.

Function
REQ-016 is_sc_rd SHALL be 1 in every cycle except the FLUSH cycle (no other backpressure).
REQ-017 Each accepted cycle SHALL compact the valid input lanes in ascending lane order behind the residue (0..3 held lanes, oldest first).
REQ-018 If residue + new lanes >= 4, the block SHALL emit the first 4 as a full beat (pk_vld=4'b1111) next cycle; the rest SHALL become the new residue.
REQ-019 If residue + new lanes < 4 and sc_is_eob == MIDDLE, the block SHALL emit nothing (pk_vld=0) and hold the combined lanes as residue.
REQ-020 Output latency SHALL be exactly 1 cycle from input to registered output. Non-emitting cycles SHALL drive pk_vld=0, pk_eob=MIDDLE, pk_build_error=0, and pk_cnt, pk_symbol, pk_seq_id, pk_entry_cnt = 0.
REQ-021 On sc_is_eob != MIDDLE with total lanes (residue + new) T: if T <= 4, the block SHALL emit one final beat with pk_vld = thermometer(T) and trailer attached. T=0 SHALL still produce a trailer beat with pk_vld=0.
REQ-022 On sc_is_eob != MIDDLE with T in 5..7, the block SHALL emit a full beat with pk_eob=MIDDLE, enter FLUSH, and emit thermometer(T-4) with the trailer next cycle.
REQ-023 State machine: IDLE/RUN (single accepting state) -> FLUSH on REQ-022. FLUSH -> RUN unconditionally after one cycle.
REQ-024 During FLUSH, trailer values SHALL be held in registers captured at the eob cycle.
REQ-025 Any sc_is_vld != 0 or sc_is_eob != MIDDLE during FLUSH SHALL set pk_overrun; that input SHALL be dropped.
REQ-026 The entry counter SHALL add the lanes emitted per beat. It saturates at 2^ENT_W-1.
REQ-027 pk_entry_cnt SHALL present the total including the final beat. The counter and residue SHALL clear after the trailer beat.
REQ-028 pk_cnt and pk_symbol lanes at or above popcount(pk_vld) SHALL be 0.
REQ-029 Counts SHALL pass through unmodified. There is no merging of equal symbols.

Reset
REQ-030 On rst_n=0: pk_vld=0, pk_cnt=0, pk_symbol=0, pk_seq_id=0, pk_eob=MIDDLE, pk_build_error=0, pk_entry_cnt=0, pk_overrun=0, residue empty, state RUN, and is_sc_rd=0 while reset is asserted.
REQ-031 Reset asserted mid-frame or in FLUSH SHALL discard residue and trailer with no further output.
REQ-032 pk_overrun SHALL clear only on reset.

Verification
REQ-033 vld=1111 for 3 cycles, then eob vld=0000 -> three full beats, then trailer beat pk_vld=0000, pk_entry_cnt=12.
REQ-034 vld=0101 (A,B), then 1011 (C,D,E) -> beat 2 emits A,B,C,D (1111) and residue = E. Next eob cycle with vld=0000 -> pk_vld=0001 (E), pk_entry_cnt=5.
REQ-035 Residue 3, eob cycle vld=1111 -> full beat (pk_eob=MIDDLE), is_sc_rd=0 next cycle, then pk_vld=0111 with trailer seq_id=0x5A and build_error=1.
REQ-036 Repeat REQ-035 with vld=0001 injected during FLUSH -> pk_overrun=1 and stays 1, the injected lane is absent from the output, and pk_entry_cnt=7.
REQ-037 rst_n pulsed low with residue 2 -> all outputs at reset values; the next frame with eob vld=0011 gives pk_vld=0011 and pk_entry_cnt=2.
REQ-038 Random lane patterns over 584-entry frames -> the emitted symbol sequence SHALL equal the in-order valid input sequence, and pk_vld SHALL always be thermometer.
